timer_seq: RTL

Multi-channel programmable delay sequencer. On a start request it fetches `NUM_CH` delay targets from consecutive words of a 64-bit-wide synchronous memory at `BASE_ADDR`. It then runs each delay in order, pulses a per-channel completion strobe, and raises `done` after the last channel. It sits beside the Saber datapath blocks as the generalised, restartable replacement for the single-shot memory-programmed cycle timer.

---
 rtl/timer_seq_pkg.sv | 15 +
 rtl/timer_seq_if.sv | 28 ++
 rtl/timer_seq_counter.sv | 42 ++++
 rtl/timer_seq.sv | 107 ++++++++++
 4 files changed

// File: rtl/timer_seq_pkg.sv
// rtl/timer_seq_pkg.sv - state encoding shared by the timer_seq slice
package timer_seq_pkg;

  localparam int STATE_W = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_ADDR  = 3'd1;
  localparam state_t S_LOAD  = 3'd2;
  localparam state_t S_COUNT = 3'd3;
  localparam state_t S_NEXT  = 3'd4;
  localparam state_t S_DONE  = 3'd7;

endpackage

// File: rtl/timer_seq_if.sv
// rtl/timer_seq_if.sv - control/memory bundle for timer_seq; abort wire only with TIMER_SEQ_ABORT_EN
interface timer_seq_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 64,
  parameter int NUM_CH = 4
);

  logic              start;
  logic [ADDR_W-1:0] read_address;
  logic [DATA_W-1:0] read_data;
  logic              busy;
  logic [NUM_CH-1:0] ch_done;
  logic              done;
`ifdef TIMER_SEQ_ABORT_EN
  logic              abort;

  modport master (output start, output read_data, output abort,
                  input read_address, input busy, input ch_done, input done);
  modport slave  (input start, input read_data, input abort,
                  output read_address, output busy, output ch_done, output done);
`else
  modport master (output start, output read_data,
                  input read_address, input busy, input ch_done, input done);
  modport slave  (input start, input read_data,
                  output read_address, output busy, output ch_done, output done);
`endif

endinterface

// File: rtl/timer_seq_counter.sv
// rtl/timer_seq_counter.sv - per-channel delay counter with loadable target and match flag
module timer_seq_counter #(
  parameter int CNT_W = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             target_load,
  input  logic [CNT_W-1:0] target_in,
  output logic             hit
);

  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] target;

  // Elapsed-cycle counter: cleared when a new target arrives, advanced while counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter <= '0;
    end else if (clr) begin
      counter <= '0;
    end else if (inc) begin
      counter <= counter + CNT_W'(1);
    end
  end

  // Target register: captured from the memory word during LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target <= '0;
    end else if (target_load) begin
      target <= target_in;
    end
  end

  // Counting stops on the match, so the counter can never pass the target.
  always_comb begin
    hit = (counter == target);
  end

endmodule

// File: rtl/timer_seq.sv
// rtl/timer_seq.sv - multi-channel memory-programmed delay sequencer; optional abort via TIMER_SEQ_ABORT_EN
module timer_seq
  import timer_seq_pkg::*;
#(
  parameter int CNT_W     = 33,
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 9,
  parameter int NUM_CH    = 4,
  parameter int BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst,
  timer_seq_if.slave    bus
);

  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_CH = ADDR_W'(NUM_CH - 1);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] ch;
  logic              hit;
  logic              abort_req;
  logic              in_seq;
  logic              seq_go;
  logic              ch_step;
  logic              cnt_load;
  logic              cnt_inc;
  logic [DATA_W-1:0] unused_data;

  // Only the low CNT_W bits of the memory word form the target.
  assign unused_data = bus.read_data;

`ifdef TIMER_SEQ_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  // Decode of the registered state used by both next-state and control logic.
  always_comb begin
    in_seq   = (state_q == S_ADDR) || (state_q == S_LOAD) ||
               (state_q == S_COUNT) || (state_q == S_NEXT);
    seq_go   = ((state_q == S_IDLE) || (state_q == S_DONE)) && bus.start;
    ch_step  = (state_q == S_NEXT) && (ch != LAST_CH) && !abort_req;
    cnt_load = (state_q == S_LOAD);
    cnt_inc  = (state_q == S_COUNT) && !hit;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort pre-empts every in-sequence transition, start wins outside one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_ADDR;
      S_ADDR:  state_d = S_LOAD;
      S_LOAD:  state_d = S_COUNT;
      S_COUNT: if (hit) state_d = S_NEXT;
      S_NEXT:  state_d = (ch == LAST_CH) ? S_DONE : S_ADDR;
      S_DONE:  if (bus.start) state_d = S_ADDR;
      default: state_d = S_IDLE;
    endcase
    if (abort_req && in_seq) begin
      state_d = S_IDLE;
    end
  end

  // Channel index: reset on every (re)start, advanced when leaving NEXT for another channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch <= '0;
    end else if (seq_go) begin
      ch <= '0;
    end else if (ch_step) begin
      ch <= ch + ADDR_W'(1);
    end
  end

  timer_seq_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk         (clk),
    .rst         (rst),
    .clr         (cnt_load),
    .inc         (cnt_inc),
    .target_load (cnt_load),
    .target_in   (bus.read_data[CNT_W-1:0]),
    .hit         (hit)
  );

  // Outputs come only from registered state and ch, never from inputs.
  always_comb begin
    bus.read_address = BASE_A + ch;
    bus.busy         = in_seq;
    bus.done         = (state_q == S_DONE);
    bus.ch_done      = (state_q == S_NEXT) ? (NUM_CH'(1) << ch) : '0;
  end

endmodule
